// File: rtl/board_renderer_pkg.sv
// rtl/board_renderer_pkg.sv - shared colours, tile status bit positions and FSM encoding
package board_renderer_pkg;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] WHITE   = 3'b111;

    // Tile status word: {stepped, flagged, mined, cursor, count[3:0]}
    localparam int BIT_STEPPED = 7;
    localparam int BIT_FLAGGED = 6;
    localparam int BIT_MINED   = 5;
    localparam int BIT_CURSOR  = 4;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

endpackage

// File: rtl/board_renderer_tile_neighbours.sv
// rtl/board_renderer_tile_neighbours.sv - edge-aware mine count of the 8 neighbours of one tile
module tile_neighbours #(
    parameter int COLS = 8,
    parameter int ROWS = 8
) (
    input  logic [COLS*ROWS-1:0] mine_map,
    input  logic [3:0]           col,
    input  logic [3:0]           row,
    output logic [3:0]           count
);
    localparam int N  = COLS * ROWS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] nb_idx;
    int            nr;
    int            nc;

    // Off-board neighbours are skipped so a tile never sees the far edge through index wrap.
    always_comb begin
        count  = '0;
        nb_idx = '0;
        nr     = 0;
        nc     = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(row) + dr;
                nc = int'(col) + dc;
                if ((dr != 0 || dc != 0) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
                    nb_idx = IW'(nr * COLS + nc);
                    count  = count + {3'b000, mine_map[nb_idx]};
                end
            end
        end
    end

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - start/busy/done frame pass streaming one tile pixel per cycle to the plot sink
module board_renderer
    import board_renderer_pkg::*;
#(
    parameter int COLS   = 8,
    parameter int ROWS   = 8,
    parameter int TILE_W = 19,
    parameter int TILE_H = 14,
    parameter int X0     = 0,
    parameter int Y0     = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 dirty_mode,
    input  logic [COLS*ROWS-1:0] mine_map,
    input  logic [COLS*ROWS-1:0] flag_map,
    input  logic [COLS*ROWS-1:0] step_map,
    input  logic [COLS*ROWS-1:0] pos_map,
    input  logic [COLS*ROWS-1:0] dirty_map,
    input  logic                 plot_ready,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           color,
    output logic                 plot,
    output logic                 busy,
    output logic                 done
);
    localparam int          N        = COLS * ROWS;
    localparam int          IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0]  PX_LAST  = 8'(TILE_W - 1);
    localparam logic [7:0]  PY_LAST  = 8'(TILE_H - 1);
    localparam logic [3:0]  COL_LAST = 4'(COLS - 1);
    localparam logic [3:0]  ROW_LAST = 4'(ROWS - 1);
    localparam int          MIN_WH   = (TILE_W < TILE_H) ? TILE_W : TILE_H;

    state_t        state, state_n;
    logic [3:0]    col, row, col_n, row_n, col_adv, row_adv;
    logic [7:0]    px, py, px_n, py_n;
    logic [7:0]    tile, tile_n, snap;
    logic          dmode, dmode_n;
    logic [7:0]    x_n;
    logic [6:0]    y_n;
    logic [2:0]    color_n;
    logic          plot_n, busy_n, done_n;
    logic [3:0]    nb_count;
    logic [IW-1:0] idx;
    logic          last_tile;

    tile_neighbours #(.COLS(COLS), .ROWS(ROWS)) u_nb (
        .mine_map (mine_map),
        .col      (col),
        .row      (row),
        .count    (nb_count)
    );

    function automatic logic [7:0] pix_x(input logic [3:0] c, input logic [7:0] p);
        return 8'(X0 + int'(c) * TILE_W + int'(p));
    endfunction

    function automatic logic [6:0] pix_y(input logic [3:0] r, input logic [7:0] p);
        return 7'(Y0 + int'(r) * TILE_H + int'(p));
    endfunction

    // Priority: cursor frame, revealed mine, revealed count dots, flag glyph, covered.
    function automatic logic [2:0] pix_color(input logic [7:0] t, input logic [7:0] pxi, input logic [7:0] pyi);
        int hx, hy, dx, dy, cnt;
        logic [2:0] c;
        hx  = int'(pxi);
        hy  = int'(pyi);
        dx  = hx - TILE_W / 2;
        dy  = hy - TILE_H / 2;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        cnt = int'(t[3:0]);
        c   = BLACK;
        if (t[BIT_CURSOR] && (hx == 0 || hx == TILE_W - 1 || hy == 0 || hy == TILE_H - 1)) begin
            c = CYAN;
        end else if (t[BIT_STEPPED] && t[BIT_MINED]) begin
            c = (dx + dy <= MIN_WH / 3) ? BLACK : WHITE;
        end else if (t[BIT_STEPPED]) begin
            c = GREEN;
            for (int k = 0; k < 8; k++) begin
                if (k < cnt && hx == 2 + 2 * (k % 4) && hy == 2 + 2 * (k / 4)) c = MAGENTA;
            end
        end else if (t[BIT_FLAGGED]) begin
            if (hx >= TILE_W / 3 && hx < TILE_W / 2 && hy >= TILE_H / 4 && hy < TILE_H / 2)
                c = RED;
            else if (hx == TILE_W / 2 && hy >= TILE_H / 4 && hy < 3 * TILE_H / 4)
                c = WHITE;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            px    <= '0;
            py    <= '0;
            tile  <= '0;
            dmode <= 1'b0;
            x     <= '0;
            y     <= '0;
            color <= '0;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            px    <= px_n;
            py    <= py_n;
            tile  <= tile_n;
            dmode <= dmode_n;
            x     <= x_n;
            y     <= y_n;
            color <= color_n;
            plot  <= plot_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        idx       = IW'(int'(row) * COLS + int'(col));
        snap      = {step_map[idx], flag_map[idx], mine_map[idx], pos_map[idx], nb_count};
        last_tile = (col == COL_LAST) && (row == ROW_LAST);
        col_adv   = (col == COL_LAST) ? 4'd0 : col + 4'd1;
        row_adv   = (col == COL_LAST) ? row + 4'd1 : row;

        state_n = state;
        col_n   = col;
        row_n   = row;
        px_n    = px;
        py_n    = py;
        tile_n  = tile;
        dmode_n = dmode;
        x_n     = x;
        y_n     = y;
        color_n = color;
        plot_n  = plot;

        case (state)
            IDLE: begin
                plot_n = 1'b0;
                if (start) begin
                    dmode_n = dirty_mode;
                    col_n   = '0;
                    row_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (dmode && !dirty_map[idx]) begin
                    if (last_tile) begin
                        state_n = DONE;
                    end else begin
                        col_n = col_adv;
                        row_n = row_adv;
                    end
                end else begin
                    // First pixel uses the fresh snapshot, since tile is only written this edge.
                    tile_n  = snap;
                    px_n    = '0;
                    py_n    = '0;
                    x_n     = pix_x(col, 8'd0);
                    y_n     = pix_y(row, 8'd0);
                    color_n = pix_color(snap, 8'd0, 8'd0);
                    plot_n  = 1'b1;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                if (plot && plot_ready) begin
                    if (px == PX_LAST) begin
                        px_n = '0;
                        if (py == PY_LAST) begin
                            py_n   = '0;
                            plot_n = 1'b0;
                            if (last_tile) begin
                                state_n = DONE;
                            end else begin
                                state_n = LOAD;
                                col_n   = col_adv;
                                row_n   = row_adv;
                            end
                        end else begin
                            py_n = py + 8'd1;
                        end
                    end else begin
                        px_n = px + 8'd1;
                    end
                    if (plot_n) begin
                        x_n     = pix_x(col, px_n);
                        y_n     = pix_y(row, py_n);
                        color_n = pix_color(tile, px_n, py_n);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == LOAD) || (state_n == DRAW);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - directed self-checking bench for board_renderer
module tb_board_renderer;
    import board_renderer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        dirty_mode = 1'b0;
    logic        plot_ready = 1'b1;
    logic [63:0] mine_map = '0, flag_map = '0, step_map = '0, pos_map = '0, dirty_map = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        plot, busy, done;

    logic        start_s = 1'b0;
    logic        dmode_s = 1'b0;
    logic        ready_s = 1'b1;
    logic [3:0]  zmap = '0;
    logic [7:0]  x_s;
    logic [6:0]  y_s;
    logic [2:0]  color_s;
    logic        plot_s, busy_s, done_s;

    board_renderer dut (
        .clk(clk), .resetn(resetn), .start(start), .dirty_mode(dirty_mode),
        .mine_map(mine_map), .flag_map(flag_map), .step_map(step_map),
        .pos_map(pos_map), .dirty_map(dirty_map), .plot_ready(plot_ready),
        .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
    );

    board_renderer #(.COLS(2), .ROWS(2), .TILE_W(10), .TILE_H(8)) dut_s (
        .clk(clk), .resetn(resetn), .start(start_s), .dirty_mode(dmode_s),
        .mine_map(zmap), .flag_map(zmap), .step_map(zmap),
        .pos_map(zmap), .dirty_map(zmap), .plot_ready(ready_s),
        .x(x_s), .y(y_s), .color(color_s), .plot(plot_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int   hist[64][8];
    int   cycles, nplots, seq_bad, hold_bad, out_rect, mag_pos, mag_sum0;
    logic done_seen;
    logic held;
    logic [18:0] hold_v;
    int   cyc, np, sbad, cbad, mx, my, dcnt, pcnt;

    task automatic record(input logic dm);
        int t, k, p, ex, ey;
        k = nplots;
        nplots++;
        if (x < 152 && y < 112) begin
            t = (int'(y) / 14) * 8 + int'(x) / 19;
            hist[t][color]++;
            if (color == MAGENTA) begin
                mag_pos = int'(x) * 128 + int'(y);
                if (t == 0) mag_sum0 += int'(x) + 32 * int'(y);
            end
        end else begin
            seq_bad++;
        end
        if (!dm) begin
            t  = k / 266;
            p  = k % 266;
            ex = (t % 8) * 19 + p % 19;
            ey = (t / 8) * 14 + p / 19;
            if (int'(x) != ex || int'(y) != ey) seq_bad++;
        end else if (!(x >= 95 && x <= 113 && y <= 13)) begin
            out_rect++;
        end
    endtask

    task automatic run_pass(input logic dm, input logic tog, input int inj);
        for (int i = 0; i < 64; i++) for (int c = 0; c < 8; c++) hist[i][c] = 0;
        nplots = 0; seq_bad = 0; hold_bad = 0; out_rect = 0; mag_pos = -1; mag_sum0 = 0;
        done_seen = 1'b0; held = 1'b0; hold_v = '0;
        dirty_mode = dm;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cycles = 1;
        while (cycles < 40000) begin
            @(negedge clk);
            if (held && {x, y, color, plot} != hold_v) hold_bad++;
            held   = plot && !plot_ready;
            hold_v = {x, y, color, plot};
            if (plot && plot_ready) record(dm);
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cycles++;
            if (tog) plot_ready = ~plot_ready;
            start = (cycles == inj);
        end
        start = 1'b0;
        plot_ready = 1'b1;
        check("pass_done_seen", int'(done_seen), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("reset_x", int'(x), 0);
        check("reset_y", int'(y), 0);
        check("reset_color", int'(color), 0);
        check("reset_plot", int'(plot), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        // 2x2 board, 10x8 tiles, all maps clear
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        cyc = 1; np = 0; sbad = 0; cbad = 0; mx = 0; my = 0; done_seen = 1'b0;
        while (cyc < 1000) begin
            @(negedge clk);
            if (cyc == 1) check("small_busy_after_start", int'(busy_s), 1);
            if (plot_s) begin
                if (int'(x_s) != ((np / 80) % 2) * 10 + (np % 80) % 10 ||
                    int'(y_s) != ((np / 80) / 2) * 8 + (np % 80) / 10) sbad++;
                if (color_s != 3'b000) cbad++;
                if (int'(x_s) > mx) mx = int'(x_s);
                if (int'(y_s) > my) my = int'(y_s);
                np++;
            end
            if (done_s) begin
                done_seen = 1'b1;
                break;
            end
            @(posedge clk); #1 cyc++;
        end
        check("small_done_seen", int'(done_seen), 1);
        check("small_done_cycles", cyc, 325);
        check("small_plots", np, 320);
        check("small_order", sbad, 0);
        check("small_nonblack", cbad, 0);
        check("small_max_x", mx, 19);
        check("small_max_y", my, 15);

        // dirty mode, nothing dirty
        dirty_map = '0;
        run_pass(1'b1, 1'b0, -1);
        check("empty_dirty_cycles", cycles, 65);
        check("empty_dirty_plots", nplots, 0);

        // dirty mode, tile 5 only, with a start pulse while busy
        dirty_map = 64'h20;
        run_pass(1'b1, 1'b0, 100);
        check("dirty5_cycles", cycles, 331);
        check("dirty5_plots", nplots, 266);
        check("dirty5_outside", out_rect, 0);
        check("dirty5_bad", seq_bad, 0);
        dirty_map = '0;

        // reset in the middle of a draw
        dirty_mode = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("mid_busy", int'(busy), 1);
        check("mid_plot", int'(plot), 1);
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        dcnt = 0; pcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcnt++;
            if (plot) pcnt++;
        end
        check("rst_no_done", dcnt, 0);
        check("rst_no_plot", pcnt, 0);

        // full pass: mine at tile 7, tiles 6 and 8 stepped
        mine_map = 64'h80;
        step_map = 64'h140;
        run_pass(1'b0, 1'b0, -1);
        check("a_cycles", cycles, 17089);
        check("a_plots", nplots, 17024);
        check("a_order", seq_bad, 0);
        check("a_t6_magenta", hist[6][MAGENTA], 1);
        check("a_t6_green", hist[6][GREEN], 265);
        check("a_magenta_xy", mag_pos, 116 * 128 + 2);
        check("a_t8_green", hist[8][GREEN], 266);
        check("a_t7_black", hist[7][BLACK], 266);

        // full pass with toggling ready: corner count, cursor, flag, revealed mine
        mine_map = 64'h302;
        step_map = 64'h201;
        pos_map  = 64'h8000_0000_0000_0000;
        flag_map = 64'h4000_0000_0000_0000;
        run_pass(1'b0, 1'b1, -1);
        check("b_plots", nplots, 17024);
        check("b_order", seq_bad, 0);
        check("b_hold", hold_bad, 0);
        check("b_t0_magenta", hist[0][MAGENTA], 3);
        check("b_t0_dot_pos", mag_sum0, 204);
        check("b_t63_cyan", hist[63][CYAN], 62);
        check("b_t63_black", hist[63][BLACK], 204);
        check("b_t62_red", hist[62][RED], 12);
        check("b_t62_white", hist[62][WHITE], 7);
        check("b_t9_black", hist[9][BLACK], 41);
        check("b_t9_white", hist[9][WHITE], 225);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
